bcd_cascade_counter: RTL and testbench

//  Consumes the one-cycle enable strobe produced by the clock-enable divider and counts it in

---
 rtl/bcd_cascade_counter.sv | 91 +++++++++
 tb/tb_bcd_cascade_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_cascade_counter.sv
// Cascaded BCD decade counter driven by a one-cycle enable strobe on the fast clock.
// Optional feature macro: COUNT_DOWN_EN adds a countDown input for decrementing.
module bcd_cascade_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clockIn,
    input  logic                  reset,
    input  logic                  enablePulse,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadValue,
`ifdef COUNT_DOWN_EN
    input  logic                  countDown,
`endif
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  carryOut,
    output logic                  overflow
);

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                ripple;
    logic                down;

    // enablePulse is a level-sampled strobe: every cycle it is high (without clear/load)
    // counts exactly one event; there is no handshake back to the producer.
    always_comb begin
        bcd_d   = bcd_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        ripple  = 1'b0;
`ifdef COUNT_DOWN_EN
        down    = countDown;
`else
        down    = 1'b0;
`endif
        if (clear) begin
            bcd_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                bcd_d[4*k +: 4] = (loadValue[4*k +: 4] > 4'd9) ? 4'd9 : loadValue[4*k +: 4];
            end
            ovf_d = 1'b0;
        end else if (enablePulse) begin
            // ripple stays high only while every lower digit sits at its rollover value
            ripple = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (ripple) begin
                    if (down) begin
                        if (bcd_q[4*k +: 4] == 4'd0) begin
                            bcd_d[4*k +: 4] = 4'd9;
                        end else begin
                            bcd_d[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (bcd_q[4*k +: 4] >= 4'd9) begin
                            bcd_d[4*k +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
            if (ripple) begin
                carry_d = 1'b1;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcdOut   = bcd_q;
    assign carryOut = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Scoreboard bench for bcd_cascade_counter: integer reference model, expected queue, monitor.
module tb_bcd_cascade_counter;

    localparam int DIGITS = 2;
    localparam int BW     = 4 * DIGITS;
    localparam int W      = BW + 2;
    localparam int MODN   = 100;

    logic          clockIn;
    logic          reset;
    logic          enablePulse;
    logic          clear;
    logic          load;
    logic [BW-1:0] loadValue;
`ifdef COUNT_DOWN_EN
    logic          countDown;
`endif
    logic [BW-1:0] bcdOut;
    logic          carryOut;
    logic          overflow;

    bcd_cascade_counter #(.DIGITS(DIGITS)) dut (
        .clockIn     (clockIn),
        .reset       (reset),
        .enablePulse (enablePulse),
        .clear       (clear),
        .load        (load),
        .loadValue   (loadValue),
`ifdef COUNT_DOWN_EN
        .countDown   (countDown),
`endif
        .bcdOut      (bcdOut),
        .carryOut    (carryOut),
        .overflow    (overflow)
    );

    // clock / reset
    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    logic [W-1:0] exp_q[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int carry_seen = 0;
    int model_val  = 0;
    bit model_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // driver: apply one cycle of inputs at negedge and push the expected post-edge result
    task automatic drive_cycle(input bit rst, input bit en, input bit clr, input bit ld,
                               input logic [BW-1:0] lv, input bit dn);
        bit carry;
        bit dn_eff;
        int nib;
        @(negedge clockIn);
        reset       = rst;
        enablePulse = en;
        clear       = clr;
        load        = ld;
        loadValue   = lv;
`ifdef COUNT_DOWN_EN
        countDown   = dn;
        dn_eff      = dn;
`else
        dn_eff      = 1'b0;
`endif
        carry = 1'b0;
        if (!rst) begin
            model_val = 0;
            model_ovf = 1'b0;
        end else if (clr) begin
            model_val = 0;
            model_ovf = 1'b0;
        end else if (ld) begin
            model_val = 0;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                nib = int'(lv[4*k +: 4]);
                model_val = model_val * 10 + ((nib > 9) ? 9 : nib);
            end
            model_ovf = 1'b0;
        end else if (en) begin
            if (dn_eff) begin
                carry     = (model_val == 0);
                model_val = (model_val + MODN - 1) % MODN;
            end else begin
                carry     = (model_val == MODN - 1);
                model_val = (model_val + 1) % MODN;
            end
            if (carry) model_ovf = 1'b1;
        end
        exp_q.push_back({to_bcd(model_val), carry, model_ovf});
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clockIn);
        #2;
    endtask

    // monitor / scoreboard
    always @(posedge clockIn) begin
        logic [W-1:0] e;
        #1;
        if (carryOut === 1'b1) carry_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", 32'({bcdOut, carryOut, overflow}), 32'(e));
        end
    end

    initial begin
        reset       = 1'b0;
        enablePulse = 1'b0;
        clear       = 1'b0;
        load        = 1'b0;
        loadValue   = '0;
`ifdef COUNT_DOWN_EN
        countDown   = 1'b0;
`endif
        #23;
        check("reset_state", 32'({bcdOut, carryOut, overflow}), 32'h0);
        idle(2);

        // mid-count asynchronous reset at 37, with a strobe active
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 1'b0);
        settle();
        enablePulse = 1'b1;
        reset       = 1'b0;
        model_val   = 0;
        model_ovf   = 1'b0;
        #1;
        check("async_reset", 32'({bcdOut, carryOut, overflow}), 32'h0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        strobe(3);
        settle();
        check("resume_after_reset", 32'(bcdOut), 32'h03);

        // 10 isolated strobes from 00
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            strobe(1);
            idle(1 + $urandom_range(0, 2));
        end
        settle();
        check("ten_strobes", 32'(bcdOut), 32'h10);

        // 100 strobes from 00: full wrap
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        settle();
        carry_seen = 0;
        strobe(100);
        idle(2);
        settle();
        check("hundred_value", 32'(bcdOut), 32'h00);
        check("hundred_carry_count", 32'(carry_seen), 32'd1);
        check("hundred_overflow", 32'(overflow), 32'd1);

        // continuous strobes from 95
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h95, 1'b0);
        settle();
        carry_seen = 0;
        strobe(25);
        idle(1);
        settle();
        check("burst_value", 32'(bcdOut), 32'h20);
        check("burst_carry_count", 32'(carry_seen), 32'd1);

        // load clamp with simultaneous strobe, then clear+load+strobe
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0);
        settle();
        check("load_clamp", 32'(bcdOut), 32'h93);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        settle();
        check("clear_priority", 32'(bcdOut), 32'h00);

        // reach 99 with overflow set, then clear
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        strobe(1);
        strobe(99);
        settle();
        check("at_99_value", 32'(bcdOut), 32'h99);
        check("at_99_overflow", 32'(overflow), 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        settle();
        check("clear_all", 32'({bcdOut, carryOut, overflow}), 32'h0);

`ifdef COUNT_DOWN_EN
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        settle();
        check("down_borrow", 32'(bcdOut), 32'h09);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        settle();
        check("down_underflow", 32'({bcdOut, carryOut, overflow}), 32'({8'h99, 2'b11}));
`endif

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive_cycle(($urandom_range(0, 299) != 0),
                        ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 39) == 0),
                        BW'($urandom),
                        ($urandom_range(0, 1) == 1));
        end
        idle(2);
        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
